// File: rtl/dcj11_bus_pkg.sv
// rtl/dcj11_bus_pkg.sv - AIO codes, ODT addresses, FSM states and AIO class decode for the DCJ11 bus master
package dcj11_bus_pkg;

  // AIO codes driven during the address phase of a J11 bus cycle
  localparam logic [3:0] AIO_NONIO        = 4'b1111;
  localparam logic [3:0] AIO_GPREAD       = 4'b1110;
  localparam logic [3:0] AIO_INTACK       = 4'b1101;
  localparam logic [3:0] AIO_IREADRQ      = 4'b1100;
  localparam logic [3:0] AIO_RMWNBL       = 4'b1011;
  localparam logic [3:0] AIO_RMWBL        = 4'b1010;
  localparam logic [3:0] AIO_DREAD        = 4'b1001;
  localparam logic [3:0] AIO_IREADDM      = 4'b1000;
  localparam logic [3:0] AIO_GPWRITE      = 4'b0101;
  localparam logic [3:0] AIO_BUSBYTEWRITE = 4'b0011;
  localparam logic [3:0] AIO_BUSWORDWRITE = 4'b0001;

  // Console ODT register block (octal 177560..177566)
  localparam logic [15:0] ODT_RCSR = 16'o177560;
  localparam logic [15:0] ODT_RBUF = 16'o177562;
  localparam logic [15:0] ODT_XCSR = 16'o177564;
  localparam logic [15:0] ODT_XBUF = 16'o177566;

  localparam int unsigned TIMER_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AHOLD,
    ST_DSET,
    ST_STRB,
    ST_DHOLD
  } bus_state_e;

  typedef enum logic [1:0] {
    CLS_READ,
    CLS_WRITE,
    CLS_NONIO,
    CLS_ERR
  } aio_class_e;

  // INTACK is deliberately not a supported read: it falls into CLS_ERR
  function automatic aio_class_e aio_class(input logic [3:0] aio);
    case (aio)
      AIO_GPREAD, AIO_IREADRQ, AIO_RMWNBL,
      AIO_RMWBL, AIO_DREAD, AIO_IREADDM:                 aio_class = CLS_READ;
      AIO_GPWRITE, AIO_BUSBYTEWRITE, AIO_BUSWORDWRITE:   aio_class = CLS_WRITE;
      AIO_NONIO:                                         aio_class = CLS_NONIO;
      default:                                           aio_class = CLS_ERR;
    endcase
  endfunction

endpackage

// File: rtl/dcj11_phase_timer.sv
// rtl/dcj11_phase_timer.sv - 4-bit loadable down-counter timing each bus phase
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         load load_value (takes priority over counting)
//   load_value   phase length in cycles (1..15)
//   done         high in the last cycle of the phase
module dcj11_phase_timer
  import dcj11_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  // Loaded with N on entry, so the phase spans counts N..1
  assign done = (count == TIMER_W'(1));

endmodule

// File: rtl/dcj11_bus_master.sv
// rtl/dcj11_bus_master.sv - DCJ11 DAL/AIO bus-cycle initiator driven from a command port
// Ports:
//   sys_clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake (ready only in IDLE)
//   cmd_aio, cmd_addr, cmd_wdata        AIO code, byte address / GP code, write data
//   rsp_valid, rsp_rdata, rsp_err       one-cycle completion with read data / error flag
//   dal_out, dal_oe, dal_in             multiplexed DAL pad drive, enable and input
//   aio_out, ale_n, sctl_n, bufctl_n    J11 bus control lines
module dcj11_bus_master
  import dcj11_bus_pkg::*;
#(
  parameter int unsigned T_AS  = 2,
  parameter int unsigned T_AH  = 2,
  parameter int unsigned T_DS  = 3,
  parameter int unsigned T_STB = 4,
  parameter int unsigned T_DH  = 2
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_aio,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] dal_out,
  output logic        dal_oe,
  input  logic [15:0] dal_in,
  output logic [3:0]  aio_out,
  output logic        ale_n,
  output logic        sctl_n,
  output logic        bufctl_n
);

  localparam logic [TIMER_W-1:0] LEN_AS  = TIMER_W'(T_AS);
  localparam logic [TIMER_W-1:0] LEN_AH  = TIMER_W'(T_AH);
  localparam logic [TIMER_W-1:0] LEN_DS  = TIMER_W'(T_DS);
  localparam logic [TIMER_W-1:0] LEN_STB = TIMER_W'(T_STB);
  localparam logic [TIMER_W-1:0] LEN_DH  = TIMER_W'(T_DH);

  bus_state_e state, state_nx;
  aio_class_e cls_q;
  logic [3:0]  aio_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] wdata_lane;

  logic               accept;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_done;
  logic               rsp_fire;
  logic               rsp_err_fire;
  logic               rd_capture;

  dcj11_phase_timer u_timer (
    .clk        (sys_clk),
    .rst        (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  assign accept = cmd_valid && (state == ST_IDLE);

  // Byte writes replicate the low byte so the responder can take either lane
  assign wdata_lane = (aio_q == AIO_BUSBYTEWRITE) ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    rsp_fire     = 1'b0;
    rsp_err_fire = 1'b0;
    rd_capture   = 1'b0;
    cmd_ready    = 1'b0;
    dal_out      = 16'h0000;
    dal_oe       = 1'b0;
    aio_out      = 4'b1111;
    ale_n        = 1'b1;
    sctl_n       = 1'b1;
    bufctl_n     = 1'b1;

    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (aio_class(cmd_aio) == CLS_ERR) begin
            rsp_err_fire = 1'b1;
          end else begin
            state_nx  = ST_ADDR;
            tmr_load  = 1'b1;
            tmr_value = LEN_AS;
          end
        end
      end

      ST_ADDR: begin
        dal_oe  = 1'b1;
        dal_out = addr_q;
        aio_out = aio_q;
        if (tmr_done) begin
          state_nx  = ST_AHOLD;
          tmr_load  = 1'b1;
          tmr_value = LEN_AH;
        end
      end

      ST_AHOLD: begin
        dal_oe  = 1'b1;
        dal_out = addr_q;
        aio_out = aio_q;
        ale_n   = 1'b0;
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (cls_q == CLS_NONIO) begin
            state_nx  = ST_DHOLD;
            tmr_value = LEN_DH;
          end else begin
            state_nx  = ST_DSET;
            tmr_value = LEN_DS;
          end
        end
      end

      ST_DSET, ST_STRB: begin
        aio_out = aio_q;
        ale_n   = 1'b0;
        if (cls_q == CLS_READ) begin
          bufctl_n = 1'b0;
        end else begin
          dal_oe  = 1'b1;
          dal_out = wdata_lane;
        end
        if (state == ST_STRB) begin
          sctl_n = 1'b0;
          if (tmr_done) begin
            state_nx   = ST_DHOLD;
            tmr_load   = 1'b1;
            tmr_value  = LEN_DH;
            rd_capture = (cls_q == CLS_READ);
          end
        end else if (tmr_done) begin
          state_nx  = ST_STRB;
          tmr_load  = 1'b1;
          tmr_value = LEN_STB;
        end
      end

      ST_DHOLD: begin
        aio_out = aio_q;
        ale_n   = 1'b0;
        if (cls_q == CLS_WRITE) begin
          dal_oe  = 1'b1;
          dal_out = wdata_lane;
        end
        if (tmr_done) begin
          state_nx = ST_IDLE;
          rsp_fire = 1'b1;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      aio_q     <= 4'b1111;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      cls_q     <= CLS_NONIO;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0000;
    end else begin
      rsp_valid <= rsp_fire | rsp_err_fire;
      rsp_err   <= rsp_err_fire;
      if (accept) begin
        aio_q   <= cmd_aio;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        cls_q   <= aio_class(cmd_aio);
      end
      // Read data is captured on the strobe's trailing edge; other completions clear it
      if (rd_capture) begin
        rsp_rdata <= dal_in;
      end else if (rsp_err_fire || (rsp_fire && cls_q != CLS_READ)) begin
        rsp_rdata <= 16'h0000;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    assert (T_AS  >= 1 && T_AS  <= 15) else $error("T_AS out of range 1..15");
    assert (T_AH  >= 1 && T_AH  <= 15) else $error("T_AH out of range 1..15");
    assert (T_DS  >= 1 && T_DS  <= 15) else $error("T_DS out of range 1..15");
    assert (T_STB >= 1 && T_STB <= 15) else $error("T_STB out of range 1..15");
    assert (T_DH  >= 1 && T_DH  <= 15) else $error("T_DH out of range 1..15");
  end

endmodule

// File: tb/tb_dcj11_bus_master.sv
// tb/tb_dcj11_bus_master.sv - directed bench for dcj11_bus_master with a DAL responder model
module tb_dcj11_bus_master;
  import dcj11_bus_pkg::*;

  localparam logic [15:0] CONFIG_WORD = 16'h5A0F;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_aio;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] dal_out;
  logic        dal_oe;
  logic [15:0] dal_in;
  logic [3:0]  aio_out;
  logic        ale_n;
  logic        sctl_n;
  logic        bufctl_n;

  always #5 sys_clk = ~sys_clk;

  dcj11_bus_master #(
    .T_AS(2), .T_AH(2), .T_DS(3), .T_STB(4), .T_DH(2)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_aio   (cmd_aio),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dal_out   (dal_out),
    .dal_oe    (dal_oe),
    .dal_in    (dal_in),
    .aio_out   (aio_out),
    .ale_n     (ale_n),
    .sctl_n    (sctl_n),
    .bufctl_n  (bufctl_n)
  );

  // Responder: latch address on ALE fall, write on strobe, drive DAL when bufctl_n is low
  logic [15:0] mem [0:1023];
  logic [15:0] lat_addr = 16'h0000;
  logic [3:0]  lat_aio  = 4'b1111;
  logic [9:0]  rsp_idx;

  assign rsp_idx = lat_addr[10:1];
  assign dal_in  = !bufctl_n ? ((lat_aio == AIO_GPREAD) ? CONFIG_WORD : mem[rsp_idx]) : 16'h0000;

  always @(negedge ale_n) begin
    lat_addr = dal_out;
    lat_aio  = aio_out;
  end

  always @(posedge sys_clk) begin
    if (!sctl_n && dal_oe) begin
      if (lat_aio == AIO_BUSBYTEWRITE) begin
        if (lat_addr[0]) mem[rsp_idx][15:8] <= dal_out[15:8];
        else             mem[rsp_idx][7:0]  <= dal_out[7:0];
      end else begin
        mem[rsp_idx] <= dal_out;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-command observations, cycle n = n-th cycle after the accepting edge
  int          rsp_cyc;
  int          ale_low;
  int          sctl_low;
  int          buf_first;
  int          buf_last;
  logic        oe_in_buf;
  logic [15:0] strb_data;
  logic [15:0] got_rdata;
  logic        got_err;
  logic        ready_at_rsp;
  logic        ready_at_accept;

  task automatic do_cmd(input logic [3:0] aio, input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge sys_clk);
    cmd_aio   = aio;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    #1 ready_at_accept = cmd_ready;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    rsp_cyc = 0; ale_low = 0; sctl_low = 0; buf_first = 0; buf_last = 0;
    oe_in_buf = 1'b0; strb_data = 16'h0000; got_rdata = 16'hxxxx; got_err = 1'bx; ready_at_rsp = 1'bx;
    for (int n = 1; n <= 40 && rsp_cyc == 0; n++) begin
      if (n > 1) begin
        @(posedge sys_clk);
        #1;
      end
      if (!ale_n)  ale_low++;
      if (!sctl_n) begin
        sctl_low++;
        strb_data = dal_out;
      end
      if (!bufctl_n) begin
        if (buf_first == 0) buf_first = n;
        buf_last = n;
        if (dal_oe) oe_in_buf = 1'b1;
      end
      if (rsp_valid) begin
        rsp_cyc      = n;
        got_rdata    = rsp_rdata;
        got_err      = rsp_err;
        ready_at_rsp = cmd_ready;
      end
    end
  endtask

  logic found;
  logic seen_rsp;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_aio   = 4'b1111;
    cmd_addr  = 16'h0000;
    cmd_wdata = 16'h0000;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ale_n",     ale_n,     1'b1);
    check("rst_sctl_n",    sctl_n,    1'b1);
    check("rst_bufctl_n",  bufctl_n,  1'b1);
    check("rst_dal_oe",    dal_oe,    1'b0);
    check("rst_dal_out",   dal_out,   16'h0000);
    check("rst_aio_out",   aio_out,   4'b1111);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err",   rsp_err,   1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    @(negedge sys_clk);
    reset = 1'b0;
    #1 check("rst_cmd_ready", cmd_ready, 1'b1);

    // Word write 0x1234 to octal 001000
    do_cmd(AIO_BUSWORDWRITE, 16'o001000, 16'h1234);
    check("ww_ready",     ready_at_accept, 1'b1);
    check("ww_rsp_cyc",   rsp_cyc,   14);
    check("ww_ale_low",   ale_low,   11);
    check("ww_sctl_low",  sctl_low,  4);
    check("ww_strb_data", strb_data, 16'h1234);
    check("ww_buf_first", buf_first, 0);
    check("ww_rsp_err",   got_err,   1'b0);
    check("ww_rdata",     got_rdata, 16'h0000);
    check("ww_ready_rsp", ready_at_rsp, 1'b1);

    // Data read back, issued back-to-back
    do_cmd(AIO_DREAD, 16'o001000, 16'hFFFF);
    check("rd_rsp_cyc",   rsp_cyc,   14);
    check("rd_rdata",     got_rdata, 16'h1234);
    check("rd_ale_low",   ale_low,   11);
    check("rd_sctl_low",  sctl_low,  4);
    check("rd_buf_first", buf_first, 5);
    check("rd_buf_last",  buf_last,  11);
    check("rd_oe_in_buf", oe_in_buf, 1'b0);

    // Byte write to the odd address lands in the high lane
    do_cmd(AIO_BUSBYTEWRITE, 16'o001001, 16'h00AB);
    check("bw_strb_data", strb_data, 16'hABAB);
    check("bw_rsp_cyc",   rsp_cyc,   14);
    do_cmd(AIO_DREAD, 16'o001000, 16'h0000);
    check("bw_rdback",    got_rdata, 16'hAB34);

    // GP read of the power-up configuration word
    do_cmd(AIO_GPREAD, 16'o000000, 16'h0000);
    check("gp_buf_first", buf_first, 5);
    check("gp_buf_last",  buf_last,  11);
    check("gp_oe_in_buf", oe_in_buf, 1'b0);
    check("gp_rdata",     got_rdata, CONFIG_WORD);
    check("gp_rsp_cyc",   rsp_cyc,   14);

    // Unsupported AIO code: immediate error response, no bus cycle
    do_cmd(4'b0111, 16'o001000, 16'h0000);
    check("err_rsp_cyc",  rsp_cyc,  1);
    check("err_flag",     got_err,  1'b1);
    check("err_ale_low",  ale_low,  0);
    check("err_sctl_low", sctl_low, 0);
    check("err_ready",    ready_at_rsp, 1'b1);

    // NONIO: short ALE pulse, no strobe, rdata cleared
    do_cmd(AIO_NONIO, 16'o000000, 16'h0000);
    check("nio_ale_low",  ale_low,   4);
    check("nio_sctl_low", sctl_low,  0);
    check("nio_rsp_cyc",  rsp_cyc,   7);
    check("nio_rdata",    got_rdata, 16'h0000);
    check("nio_err",      got_err,   1'b0);

    // Reset during the strobe of a write
    @(negedge sys_clk);
    cmd_aio   = AIO_BUSWORDWRITE;
    cmd_addr  = 16'o002000;
    cmd_wdata = 16'h5555;
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int n = 1; n <= 20 && !found; n++) begin
      if (!sctl_n) found = 1'b1;
      else begin
        @(posedge sys_clk);
        #1;
      end
    end
    check("rs_strb_reached", found, 1'b1);
    @(negedge sys_clk);
    #1 reset = 1'b1;
    #1;
    check("rs_sctl_n", sctl_n, 1'b1);
    check("rs_ale_n",  ale_n,  1'b1);
    check("rs_dal_oe", dal_oe, 1'b0);
    seen_rsp = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1 if (rsp_valid) seen_rsp = 1'b1;
    end
    @(negedge sys_clk);
    reset = 1'b0;
    #1 check("rs_ready", cmd_ready, 1'b1);
    repeat (3) begin
      @(posedge sys_clk);
      #1 if (rsp_valid) seen_rsp = 1'b1;
    end
    check("rs_no_rsp", seen_rsp, 1'b0);
    do_cmd(AIO_DREAD, 16'o001000, 16'h0000);
    check("rs_rd_cyc",   rsp_cyc,   14);
    check("rs_rd_rdata", got_rdata, 16'hAB34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
